fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have one clock domain and a synchronous, active-low reset: all state updates on the rising edge of clk only.
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  synchronous active-low reset; 0 at a rising edge clears all state.
REQ-004 run  in  1  enables instruction sequencing; sampled in IDLE and at each instruction boundary.
REQ-005 pc_count  in  8  current program counter value.
REQ-006 IncPC  out  1  program counter increment strobe.
REQ-007 LoadPC  out  1  program counter load strobe.
REQ-008 new_count  out  8  program counter load value; meaningful only while LoadPC=1.
REQ-009 mem_req  out  1  instruction-memory read request.
REQ-010 mem_addr  out  8  read address; always equal to pc_count.
REQ-011 mem_ack  in  1  read data valid; ignored while mem_req=0.
REQ-012 mem_rdata  in  8  read data.
REQ-013 zero_flag  in  1  datapath zero flag, used by JZ.
REQ-014 ir  out  8  instruction register; opcode = ir[7:4].
REQ-015 exec_valid  out  1  instruction dispatched to the datapath.
REQ-016 exec_done  in  1  datapath has completed the dispatched instruction.
REQ-017 halted  out  1  HALT state indicator.
REQ-018 retired  out  8  count of completed instructions; wraps from 0xFF to 0x00.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, DECODE, OPERAND, EXEC and HALT.
REQ-020 IDLE: all strobes are 0; the FSM moves to FETCH when run=1, otherwise it holds.
REQ-021 FETCH: mem_req=1; on mem_ack=1, ir<=mem_rdata, IncPC=1 in the same cycle, and the FSM moves to DECODE; otherwise it holds with no PC strobe.
REQ-022 DECODE (exactly 1 cycle): opcode 0xF -> HALT; opcode 0xE (JMP) or 0xD (JZ) -> OPERAND; any other opcode -> EXEC.
REQ-023 OPERAND: mem_req=1; on mem_ack=1 the FSM acts as follows, then moves to FETCH:
  - JMP, or JZ with zero_flag=1 sampled that cycle: LoadPC=1 and new_count=mem_rdata.
  - JZ with zero_flag=0: IncPC=1.
REQ-024 EXEC: exec_valid=1 continuously until a cycle with exec_done=1; that cycle is the last EXEC cycle, and exec_done is ignored in every other state.
REQ-025 Instruction boundary (JMP/JZ ack in OPERAND, or exec_done in EXEC): retired increments by 1; next state is FETCH if run=1, else IDLE.
REQ-026 HALT: halted=1, no strobes, no exit except reset; run is ignored.
REQ-027 IncPC and LoadPC SHALL never both be 1; each SHALL be a single-cycle pulse per mem_ack.
REQ-028 IncPC, LoadPC, mem_req and exec_valid SHALL be combinational from state and inputs, so the PC updates on the same edge that captures ir or the operand.
REQ-029 Minimum instruction latency: 3 cycles for a plain op (FETCH, DECODE, EXEC with immediate ack/done); 3 cycles for JMP/JZ (FETCH, DECODE, OPERAND).
REQ-030 PC wrap from 0xFF to 0x00 needs no special handling; the controller fetches from address 0x00 next.
REQ-031 run deasserted mid-instruction SHALL NOT abort the instruction; it takes effect at the next boundary.

Reset
REQ-032 While reset=0, IncPC, LoadPC, mem_req and exec_valid SHALL be forced to 0 combinationally.
REQ-033 After reset: state=IDLE, ir=0x00, retired=0x00, halted=0, new_count=0x00.
REQ-034 Reset in any state, including HALT and a pending mem_ack, SHALL return the block to IDLE on that edge, and the captured data SHALL be discarded.

Verification
REQ-035 Plain op: pc=0x10, rdata=0x35, ack immediate, exec_done after 2 cycles -> IncPC one pulse, ir=0x35, exec_valid 2 cycles, retired=1, next FETCH at 0x11.
REQ-036 JMP: rdata=0xE0, then operand 0x80 -> one IncPC, then LoadPC with new_count=0x80, no exec_valid, retired+1.
REQ-037 JZ both paths: with zero_flag=0 -> two IncPC pulses and no LoadPC; with zero_flag=1 and operand 0x42 -> LoadPC with new_count=0x42.
REQ-038 Wait states: mem_ack delayed 3 cycles -> mem_req held, mem_addr stable, no PC strobe until the ack.
REQ-039 HALT: opcode 0xF0 -> halted=1 after DECODE, stays halted with run toggling; reset=0 -> IDLE with halted=0.
REQ-040 Reset in OPERAND with mem_ack=1 -> no LoadPC/IncPC that cycle, ir=0x00 and retired=0x00 afterwards.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Fetch controller bus: PC strobes, instruction memory port,
// datapath dispatch handshake and status.
interface fetch_controller_if;
    logic       run;
    logic [7:0] pc_count;
    logic       IncPC;
    logic       LoadPC;
    logic [7:0] new_count;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       zero_flag;
    logic [7:0] ir;
    logic       exec_valid;
    logic       exec_done;
    logic       halted;
    logic [7:0] retired;

    modport master (
        input  run,
        input  pc_count,
        input  mem_ack,
        input  mem_rdata,
        input  zero_flag,
        input  exec_done,
        output IncPC,
        output LoadPC,
        output new_count,
        output mem_req,
        output mem_addr,
        output ir,
        output exec_valid,
        output halted,
        output retired
    );

    modport slave (
        output run,
        output pc_count,
        output mem_ack,
        output mem_rdata,
        output zero_flag,
        output exec_done,
        input  IncPC,
        input  LoadPC,
        input  new_count,
        input  mem_req,
        input  mem_addr,
        input  ir,
        input  exec_valid,
        input  halted,
        input  retired
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction sequencer: fetches opcodes and jump operands,
// drives the PC strobes and dispatches plain ops to the datapath.
module fetch_controller (
    input logic                clk,
    input logic                reset,
    fetch_controller_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        OPERAND,
        EXEC,
        HALT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] ir_q;
    logic [7:0] retired_q;
    logic [3:0] opcode;
    logic       take_jump;
    logic       capture;
    logic       boundary;
    logic       inc;
    logic       load;
    logic       req;
    logic       ev;

    assign opcode    = ir_q[7:4];
    assign take_jump = (opcode == 4'hE) ||
                       ((opcode == 4'hD) && bus.zero_flag);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        boundary  = 1'b0;
        inc       = 1'b0;
        load      = 1'b0;
        req       = 1'b0;
        ev        = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.run)
                    state_nxt = FETCH;
            end
            FETCH: begin
                req = 1'b1;
                if (bus.mem_ack) begin
                    capture   = 1'b1;
                    inc       = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                unique case (1'b1)
                    opcode == 4'hF:
                        state_nxt = HALT;
                    opcode == 4'hE || opcode == 4'hD:
                        state_nxt = OPERAND;
                    default:
                        state_nxt = EXEC;
                endcase
            end
            OPERAND: begin
                req = 1'b1;
                if (bus.mem_ack) begin
                    load     = take_jump;
                    inc      = !take_jump;
                    boundary = 1'b1;
                end
            end
            EXEC: begin
                ev = 1'b1;
                if (bus.exec_done)
                    boundary = 1'b1;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (boundary)
            state_nxt = bus.run ? FETCH : IDLE;
        // Reset must silence the PC and bus strobes in the same cycle.
        if (!reset) begin
            inc  = 1'b0;
            load = 1'b0;
            req  = 1'b0;
            ev   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ir_q      <= 8'h00;
            retired_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (capture)
                ir_q <= bus.mem_rdata;
            if (boundary)
                retired_q <= retired_q + 8'h01;
        end
    end

    assign bus.IncPC      = inc;
    assign bus.LoadPC     = load;
    assign bus.new_count  = load ? bus.mem_rdata : 8'h00;
    assign bus.mem_req    = req;
    assign bus.mem_addr   = bus.pc_count;
    assign bus.exec_valid = ev;
    assign bus.ir         = ir_q;
    assign bus.halted     = (state == HALT);
    assign bus.retired    = retired_q;

endmodule
